mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/mmio_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and register offsets for the MMIO UART transmitter
package uart_pkg;

  // Transmit FSM states; encodings kept fixed for compatibility with existing decode logic
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  // Register offsets relative to BASE_ADDR
  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 4-entry byte FIFO feeding the UART transmitter
module uart_tx_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [0:3];
  logic [1:0] wrPtr;
  logic [1:0] rdPtr;
  logic [2:0] count;
  logic       doPush;
  logic       doPop;

  // A push into a full FIFO is still accepted when a pop frees the head slot in the same cycle
  assign doPop  = pop && (count != 3'd0);
  assign doPush = push && ((count != 3'd4) || doPop);
  assign full   = (count == 3'd4);
  assign empty  = (count == 3'd0);
  assign dout   = mem[rdPtr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo 4
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= 2'd0;
      rdPtr <= 2'd0;
      count <= 3'd0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 2'd1;
      if (doPop)  rdPtr <= rdPtr + 2'd1;
      case ({doPush, doPop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Byte storage; contents are don't-care while the entry is not counted
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter; define UART_TX_FIFO_EN for a 4-deep queue
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          CLK_DIV    = 434
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] RWAddress,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int                    BAUD_W      = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0]     BAUD_LAST   = BAUD_W'(CLK_DIV - 1);
  localparam logic [DATA_WIDTH-1:0] TXDATA_ADDR = DATA_WIDTH'(BASE_ADDR + TXDATA_OFS);
  localparam logic [DATA_WIDTH-1:0] STATUS_ADDR = DATA_WIDTH'(BASE_ADDR + STATUS_OFS);

  txState_t          txState;
  logic [BAUD_W-1:0] baudCnt;
  logic [2:0]        bitCnt;
  logic [7:0]        shiftReg;
  logic              overflow;
  logic              txWrite;
  logic              statusRead;
  logic              bitEnd;
  logic              qPush;
  logic              qPop;
  logic              qFull;
  logic              qEmpty;
  logic [7:0]        qDout;
  logic              ovfSet;
  logic              unusedBits;

  // Only the low byte of a TXDATA store is transmitted
  assign unusedBits = ^WriteData[DATA_WIDTH-1:8];

  assign txWrite    = MemWrite && (RWAddress == TXDATA_ADDR);
  assign statusRead = MemRead && (RWAddress == STATUS_ADDR);
  assign bitEnd     = (baudCnt == BAUD_LAST);
  assign qPush      = txWrite;
  assign qPop       = (txState == IDLE) && !qEmpty;
  assign ovfSet     = txWrite && qFull && !qPop;
  assign tx_busy    = (txState != IDLE) || !qEmpty;

`ifdef UART_TX_FIFO_EN
  uart_tx_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (qPush),
    .pop   (qPop),
    .din   (WriteData[7:0]),
    .dout  (qDout),
    .full  (qFull),
    .empty (qEmpty)
  );
`else
  logic [7:0] holdData;
  logic       holdValid;

  assign qFull  = holdValid;
  assign qEmpty = !holdValid;
  assign qDout  = holdData;

  // Single holding register; a push coinciding with the pop refills it in place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdData  <= 8'd0;
      holdValid <= 1'b0;
    end else if (qPush && (!holdValid || qPop)) begin
      holdData  <= WriteData[7:0];
      holdValid <= 1'b1;
    end else if (qPop) begin
      holdValid <= 1'b0;
    end
  end
`endif

  // Frame sequencer: start bit, eight data bits LSB first, stop bit, each CLK_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txState  <= IDLE;
      tx       <= 1'b1;
      baudCnt  <= '0;
      bitCnt   <= 3'd0;
      shiftReg <= 8'd0;
    end else begin
      case (txState)
        IDLE: begin
          tx <= 1'b1;
          if (qPop) begin
            shiftReg <= qDout;
            baudCnt  <= '0;
            bitCnt   <= 3'd0;
            tx       <= 1'b0;
            txState  <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            baudCnt <= '0;
            tx      <= shiftReg[0];
            txState <= DATA;
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bitEnd) begin
            baudCnt <= '0;
            if (bitCnt == 3'd7) begin
              tx      <= 1'b1;
              txState <= STOP;
            end else begin
              tx       <= shiftReg[1];
              shiftReg <= {1'b0, shiftReg[7:1]};
              bitCnt   <= bitCnt + 3'd1;
            end
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bitEnd) begin
            baudCnt <= '0;
            txState <= IDLE;
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        default: begin
          tx      <= 1'b1;
          txState <= IDLE;
        end
      endcase
    end
  end

  // Sticky overflow; a new overflow in the same cycle as a STATUS read takes priority over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ovfSet) begin
      overflow <= 1'b1;
    end else if (statusRead) begin
      overflow <= 1'b0;
    end
  end

  // Load data is zero unless the STATUS register is being read
  always_comb begin
    RdData = '0;
    if (statusRead) RdData[2:0] = {overflow, qFull, tx_busy};
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx against a frame-level line model
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int          CLK_DIV = 4;
  localparam int          FRAME   = 10 * CLK_DIV;
  localparam int          PERIOD  = FRAME + 1;
  localparam logic [31:0] BASE    = 32'h1001_0000;
`ifdef UART_TX_FIFO_EN
  localparam int QDEPTH = 4;
`else
  localparam int QDEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] RWAddress = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] RdData;
  logic        tx;
  logic        tx_busy;

  int          nAssert = 0;
  int          nFail = 0;
  int          cyc = 0;
  logic        txLog [0:16383];
  logic [7:0]  expBytes [$];

  mmio_uart_tx #(
    .DATA_WIDTH (32),
    .BASE_ADDR  (BASE),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .RWAddress (RWAddress),
    .WriteData (WriteData),
    .RdData    (RdData),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (cyc < 16384) txLog[cyc] = tx;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  // Expected line level at cycle c for frames of expBytes starting at s0, one idle cycle apart
  function automatic logic expTx(input int c, input int s0);
    int k;
    int d;
    if (c < s0) return 1'b1;
    k = (c - s0) / PERIOD;
    d = (c - s0) % PERIOD;
    if (k >= expBytes.size()) return 1'b1;
    if (d < CLK_DIV) return 1'b0;
    if (d < 9 * CLK_DIV) return expBytes[k][(d - CLK_DIV) / CLK_DIV];
    return 1'b1;
  endfunction

  task automatic checkWave(input string tag, input int s0, input int fromC, input int toC);
    for (int c = fromC; c <= toC; c++)
      check1($sformatf("%s_tx@%0d", tag, c - s0), txLog[c], expTx(c, s0));
  endtask

  task automatic waitUntil(input int c);
    int guard = 0;
    while (cyc < c && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < c) check32("wait_bound", cyc, c);
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, output int n);
    MemWrite  = 1'b1;
    RWAddress = addr;
    WriteData = data;
    @(negedge clk);
    n = cyc;
    MemWrite  = 1'b0;
    RWAddress = 32'd0;
    WriteData = 32'd0;
  endtask

  initial begin
    int         n0;
    int         n;
    int         s0;
    int         qc;
    int         relC;
    logic       ovf;
    logic       acc;
    logic       pop;
    logic [7:0] b;
    logic [7:0] b2;

    // Reset state, with a STATUS read held during reset
    MemRead   = 1'b1;
    RWAddress = BASE + 32'd4;
    repeat (3) @(negedge clk);
    check1("rst_tx", tx, 1'b1);
    check1("rst_busy", tx_busy, 1'b0);
    check32("rst_rddata", RdData, 32'd0);
    rst       = 1'b0;
    MemRead   = 1'b0;
    RWAddress = 32'd0;
    repeat (2) @(negedge clk);

    // Single frame of 0x55 with upper bits set
    expBytes = {8'h55};
    busWrite(BASE, 32'hFFFF_FF55, n0);
    s0 = n0 + 1;
    check1("t1_busy_after_write", tx_busy, 1'b1);
    waitUntil(s0 + FRAME + 3);
    checkWave("t1", s0, n0, s0 + FRAME + 2);
    check1("t1_idle_busy", tx_busy, 1'b0);

    // Random single frames
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      expBytes = {b};
      busWrite(BASE, {24'($urandom), b}, n0);
      s0 = n0 + 1;
      waitUntil(s0 + FRAME + 3);
      checkWave($sformatf("rnd%0d", i), s0, n0, s0 + FRAME + 2);
    end

    // Two queued bytes: exactly one idle cycle between frames
    b  = 8'($urandom);
    b2 = 8'($urandom);
    expBytes = {b, b2};
    busWrite(BASE, {24'($urandom), b}, n0);
    busWrite(BASE, {24'($urandom), b2}, n);
    s0 = n0 + 1;
    waitUntil(s0 + 2 * PERIOD + 3);
    checkWave("t2", s0, n0, s0 + 2 * PERIOD + 1);
    check1("t2_gap_idle", txLog[s0 + FRAME], 1'b1);
    check1("t2_gap_start", txLog[s0 + FRAME + 1], 1'b0);
    check1("t2_idle_busy", tx_busy, 1'b0);

    // Six writes in consecutive cycles: queue depth plus the first pop are accepted
    expBytes.delete();
    qc  = 0;
    ovf = 1'b0;
    for (int j = 0; j < 6; j++) begin
      b   = 8'($urandom);
      pop = (j == 1);
      acc = (qc < QDEPTH) || pop;
      if (acc) expBytes.push_back(b);
      else     ovf = 1'b1;
      qc = qc + int'(acc) - int'(pop);
      busWrite(BASE, {24'($urandom), b}, n);
      if (j == 0) n0 = n;
    end
    MemRead   = 1'b1;
    RWAddress = BASE + 32'd4;
    #1;
    check32("ovf_status", RdData, {29'd0, ovf, (qc == QDEPTH), 1'b1});
    @(negedge clk);
    check32("ovf_status_cleared", RdData, {29'd0, 1'b0, (qc == QDEPTH), 1'b1});
    MemRead   = 1'b0;
    RWAddress = 32'd0;
    s0 = n0 + 1;
    waitUntil(s0 + expBytes.size() * PERIOD + 3);
    checkWave("burst", s0, n0, s0 + expBytes.size() * PERIOD + 1);
    check1("burst_idle_busy", tx_busy, 1'b0);

    // Reset during data bit 3 aborts the frame and discards the queued byte
    b  = 8'($urandom);
    b2 = 8'($urandom);
    expBytes = {b};
    busWrite(BASE, {24'd0, b}, n0);
    busWrite(BASE, {24'd0, b2}, n);
    s0 = n0 + 1;
    waitUntil(s0 + CLK_DIV + 3 * CLK_DIV + 1);
    rst = 1'b1;
    #1;
    check1("midrst_tx", tx, 1'b1);
    check1("midrst_busy", tx_busy, 1'b0);
    checkWave("midrst", s0, n0, s0 + CLK_DIV + 3 * CLK_DIV);
    @(negedge clk);
    rst  = 1'b0;
    relC = cyc;
    waitUntil(relC + 60);
    for (int c = relC; c <= relC + 58; c++)
      check1($sformatf("postrst_tx@%0d", c - relC), txLog[c], 1'b1);
    check1("postrst_busy", tx_busy, 1'b0);

    // Unmapped read, TXDATA read, STATUS write and unmapped write have no effect
    MemRead   = 1'b1;
    RWAddress = BASE + 32'd8;
    #1;
    check32("rd_unmapped", RdData, 32'd0);
    RWAddress = BASE;
    #1;
    check32("rd_txdata", RdData, 32'd0);
    MemRead   = 1'b0;
    RWAddress = 32'd0;
    busWrite(BASE + 32'd4, 32'h0000_005A, n0);
    busWrite(BASE + 32'd8, 32'h0000_00A5, n);
    check1("badwr_busy_now", tx_busy, 1'b0);
    waitUntil(n0 + 12);
    for (int c = n0; c <= n0 + 10; c++)
      check1($sformatf("badwr_tx@%0d", c - n0), txLog[c], 1'b1);
    check1("badwr_busy", tx_busy, 1'b0);
    MemRead   = 1'b1;
    RWAddress = BASE + 32'd4;
    #1;
    check32("badwr_status", RdData, 32'd0);
    MemRead   = 1'b0;
    RWAddress = 32'd0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
